// File: rtl/vta_mem_arb_pkg.sv
// vta_mem_arb_pkg: shared defaults, client index type and counter-width helper for the VTA memory read arbiter
package vta_mem_arb_pkg;
   localparam int ADDR_W_D = 32;
   localparam int DATA_W_D = 64;
   localparam int LEN_W_D  = 8;
   localparam int ID_W_D   = 8;
   typedef logic [2:0] idx_t;
   function automatic int cnt_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction
endpackage

// File: rtl/vta_rr_arbiter.sv
// vta_rr_arbiter: round-robin picker over NUM_REQ requests
// Ports: clock, reset (async active-low), req (request vector), adv (a grant was
// taken this cycle, move the pointer past the grantee), gnt (one-hot), idx (grantee index).
module vta_rr_arbiter import vta_mem_arb_pkg::*; #(
   parameter int NUM_REQ = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               adv,
   output logic [NUM_REQ-1:0] gnt,
   output idx_t               idx
);
   idx_t ptr;
   logic [NUM_REQ-1:0] hi, pick;
   // Prefer requests at or above the pointer; fall back to the full vector to wrap around.
   always_comb begin
      hi = '0;
      idx = '0;
      for (int k = 0; k < NUM_REQ; k++) hi[k] = req[k] && idx_t'(k) >= ptr;
      pick = |hi ? hi : req;
      for (int k = NUM_REQ - 1; k >= 0; k--) if (pick[k]) idx = idx_t'(k);
   end
   assign gnt = pick & (~pick + NUM_REQ'(1));
   always_ff @(posedge clock or negedge reset)
      if (!reset) ptr <= '0;
      else if (adv) ptr <= idx == idx_t'(NUM_REQ - 1) ? '0 : idx + idx_t'(1);
endmodule

// File: rtl/vta_mem_read_arbiter.sv
// vta_mem_read_arbiter: shares one AXI read channel (AR + R) among NUM_REQ VTA read clients
// Ports: clock, reset (async active-low); req_ar_* client requests (sliced per client),
// req_r_* routed read beats; mem_ar_* registered AR to memory (id = grantee index);
// mem_r_* read beats from memory (no backpressure); busy, err (sticky protocol error).
// Optional: define VTA_MEM_ARB_PERF_EN to add perf_grant/perf_stall 32-bit per-client counters.
module vta_mem_read_arbiter import vta_mem_arb_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = ADDR_W_D,
   parameter int DATA_W  = DATA_W_D,
   parameter int LEN_W   = LEN_W_D,
   parameter int ID_W    = ID_W_D,
   parameter int MAX_OUT = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_ar_valid,
   output logic [NUM_REQ-1:0]        req_ar_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_ar_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  req_ar_len,
   output logic [NUM_REQ-1:0]        req_r_valid,
   output logic [DATA_W-1:0]         req_r_data,
   output logic [NUM_REQ-1:0]        req_r_last,
   output logic                      mem_ar_valid,
   input  logic                      mem_ar_ready,
   output logic [ADDR_W-1:0]         mem_ar_addr,
   output logic [ID_W-1:0]           mem_ar_id,
   output logic [LEN_W-1:0]          mem_ar_len,
   input  logic                      mem_r_valid,
   input  logic [DATA_W-1:0]         mem_r_data,
   input  logic                      mem_r_last,
   input  logic [ID_W-1:0]           mem_r_id,
   output logic                      busy,
   output logic                      err
`ifdef VTA_MEM_ARB_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0]     perf_grant,
   output logic [NUM_REQ*32-1:0]     perf_stall
`endif
);
   localparam int CW = cnt_w(MAX_OUT);
   logic [CW-1:0] cnt [NUM_REQ];
   logic [NUM_REQ-1:0] elig, gnt, held, dec;
   idx_t idx;
   logic load, grant, bad_id, orphan;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cli
      assign elig[i] = req_ar_valid[i] && cnt[i] < CW'(MAX_OUT);
      assign held[i] = cnt[i] != '0;
      assign req_r_valid[i] = mem_r_valid && mem_r_id == ID_W'(i);
      assign req_r_last[i] = req_r_valid[i] && mem_r_last;
      assign dec[i] = req_r_last[i] && held[i];
   end
   vta_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clock(clock),
      .reset(reset),
      .req(elig),
      .adv(grant),
      .gnt(gnt),
      .idx(idx)
   );
   // Reset gates the grant so no client sees ready while the block is held in reset.
   assign load = (!mem_ar_valid || mem_ar_ready) && reset;
   assign req_ar_ready = load ? gnt : '0;
   assign grant = |req_ar_ready;
   assign req_r_data = mem_r_data;
   assign bad_id = mem_r_valid && int'(mem_r_id) >= NUM_REQ;
   // A last beat with nothing outstanding is still routed, but the counter stays at zero.
   assign orphan = |(req_r_last & ~held);
   assign busy = mem_ar_valid || |held;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         mem_ar_valid <= 1'b0;
         mem_ar_addr <= '0;
         mem_ar_id <= '0;
         mem_ar_len <= '0;
         err <= 1'b0;
         for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
      end else begin
         if (grant) begin
            mem_ar_valid <= 1'b1;
            mem_ar_addr <= req_ar_addr[int'(idx)*ADDR_W +: ADDR_W];
            mem_ar_id <= ID_W'(idx);
            mem_ar_len <= req_ar_len[int'(idx)*LEN_W +: LEN_W];
         end else if (mem_ar_ready) mem_ar_valid <= 1'b0;
         err <= err || bad_id || orphan;
         for (int k = 0; k < NUM_REQ; k++) cnt[k] <= cnt[k] + CW'(req_ar_ready[k]) - CW'(dec[k]);
      end
`ifdef VTA_MEM_ARB_PERF_EN
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         perf_grant <= '0;
         perf_stall <= '0;
      end else for (int k = 0; k < NUM_REQ; k++) begin
         perf_grant[k*32 +: 32] <= perf_grant[k*32 +: 32] + 32'(req_ar_ready[k]);
         perf_stall[k*32 +: 32] <= perf_stall[k*32 +: 32] + 32'(req_ar_valid[k] && !req_ar_ready[k]);
      end
`endif
endmodule

// File: tb/tb_vta_mem_read_arbiter.sv
// tb_vta_mem_read_arbiter: directed and randomized checks of the read arbiter against a behavioural model
module tb_vta_mem_read_arbiter;
   localparam int N = 4;
   localparam int MAXO = 2;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [N-1:0] req_ar_valid, req_ar_ready, req_r_valid, req_r_last;
   logic [N*32-1:0] req_ar_addr;
   logic [N*8-1:0] req_ar_len;
   logic [63:0] req_r_data, mem_r_data;
   logic mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_last, busy, err;
   logic [31:0] mem_ar_addr;
   logic [7:0] mem_ar_id, mem_ar_len, mem_r_id;
`ifdef VTA_MEM_ARB_PERF_EN
   logic [N*32-1:0] perf_grant, perf_stall;
`endif
   always #5 clock = ~clock;
   vta_mem_read_arbiter #(.NUM_REQ(N), .MAX_OUT(MAXO)) dut (
      .clock(clock),
      .reset(reset),
      .req_ar_valid(req_ar_valid),
      .req_ar_ready(req_ar_ready),
      .req_ar_addr(req_ar_addr),
      .req_ar_len(req_ar_len),
      .req_r_valid(req_r_valid),
      .req_r_data(req_r_data),
      .req_r_last(req_r_last),
      .mem_ar_valid(mem_ar_valid),
      .mem_ar_ready(mem_ar_ready),
      .mem_ar_addr(mem_ar_addr),
      .mem_ar_id(mem_ar_id),
      .mem_ar_len(mem_ar_len),
      .mem_r_valid(mem_r_valid),
      .mem_r_data(mem_r_data),
      .mem_r_last(mem_r_last),
      .mem_r_id(mem_r_id),
      .busy(busy),
      .err(err)
`ifdef VTA_MEM_ARB_PERF_EN
      ,
      .perf_grant(perf_grant),
      .perf_stall(perf_stall)
`endif
   );
   int n_chk = 0;
   int n_pass = 0;
   // behavioural model: outstanding bursts per client, next RR start, expected AR register, sticky error
   int cnt [N];
   int start;
   bit m_vld, m_err;
   logic [31:0] m_addr;
   int m_id;
   logic [7:0] m_len;
   // memory model: bursts accepted on AR, answered in order
   int qid[$];
   int qlen[$];
   int beat;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask
   task automatic model_reset();
      for (int k = 0; k < N; k++) cnt[k] = 0;
      start = 0;
      m_vld = 0;
      m_err = 0;
      m_addr = '0;
      m_id = 0;
      m_len = '0;
      qid.delete();
      qlen.delete();
      beat = 0;
   endtask
   task automatic idle();
      req_ar_valid = '0;
      mem_ar_ready = 1'b1;
      mem_r_valid = 1'b0;
      mem_r_last = 1'b0;
      mem_r_id = '0;
      mem_r_data = '0;
   endtask
   task automatic drive_mem(input int pct);
      mem_r_data = {$urandom, $urandom};
      if (qid.size() > 0 && $urandom_range(99) < pct) begin
         mem_r_valid = 1'b1;
         mem_r_id = 8'(qid[0]);
         mem_r_last = beat == qlen[0];
         if (mem_r_last) begin
            void'(qid.pop_front());
            void'(qlen.pop_front());
            beat = 0;
         end else beat++;
      end else begin
         mem_r_valid = 1'b0;
         mem_r_id = 8'($urandom_range(255));
         mem_r_last = 1'($urandom_range(1));
      end
   endtask
   // one clock: compare DUT against model, advance model, move to next negedge
   task automatic cyc();
      int g;
      int rid;
      bit can;
      logic [N-1:0] exp_rdy, exp_rv;
      #1;
      can = !m_vld || mem_ar_ready;
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && can && req_ar_valid[(start + k) % N] && cnt[(start + k) % N] < MAXO) g = (start + k) % N;
      exp_rdy = g >= 0 ? N'(1) << g : '0;
      rid = int'(mem_r_id);
      exp_rv = (mem_r_valid && rid < N) ? N'(1) << rid : '0;
      chk("ar_ready", req_ar_ready, exp_rdy);
      chk("ar_valid", mem_ar_valid, m_vld);
      chk("ar_fields", {mem_ar_addr, mem_ar_id, mem_ar_len}, {m_addr, 8'(m_id), m_len});
      chk("r_valid", req_r_valid, exp_rv);
      chk("r_last", req_r_last, mem_r_last ? exp_rv : '0);
      chk("r_data", req_r_data, mem_r_data);
      chk("busy", busy, m_vld || cnt.sum() != 0);
      chk("err", err, m_err);
      if (m_vld && mem_ar_ready) begin
         qid.push_back(m_id);
         qlen.push_back(int'(m_len));
      end
      if (mem_r_valid) begin
         if (rid >= N) m_err = 1;
         else if (mem_r_last) begin
            if (cnt[rid] == 0) m_err = 1;
            else cnt[rid]--;
         end
      end
      if (g >= 0) begin
         cnt[g]++;
         m_vld = 1;
         m_addr = req_ar_addr[g*32 +: 32];
         m_id = g;
         m_len = req_ar_len[g*8 +: 8];
         start = (g + 1) % N;
      end else if (mem_ar_ready) m_vld = 0;
      @(negedge clock);
   endtask
   // asynchronous reset assertion between clock edges; outputs must clear immediately
   task automatic async_rst();
      #3 reset = 1'b0;
      #1;
      chk("rst_ar_valid", mem_ar_valid, 1'b0);
      chk("rst_ar_fields", {mem_ar_addr, mem_ar_id, mem_ar_len}, 48'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_ready", req_ar_ready, '0);
      model_reset();
      idle();
      @(negedge clock);
      reset = 1'b1;
   endtask
   task automatic drain();
      int t;
      req_ar_valid = '0;
      mem_ar_ready = 1'b1;
      t = 0;
      while ((qid.size() > 0 || m_vld) && t < 200) begin
         drive_mem(100);
         cyc();
         t++;
      end
      mem_r_valid = 1'b0;
      cyc();
      chk("drained", qid.size(), 0);
   endtask
   initial begin
      logic [31:0] a0;
      idle();
      model_reset();
      req_ar_addr = '0;
      req_ar_len = '0;
      req_ar_valid = '1;
      repeat (2) @(negedge clock);
      #1;
      chk("init_ar_valid", mem_ar_valid, 1'b0);
      chk("init_busy", busy, 1'b0);
      chk("init_err", err, 1'b0);
      chk("init_ready", req_ar_ready, '0);
      chk("init_r_valid", req_r_valid, '0);
      req_ar_valid = '0;
      reset = 1'b1;
      @(negedge clock);
      // single burst, client 0
      req_ar_valid = 4'b0001;
      req_ar_addr[31:0] = 32'h1000;
      req_ar_len[7:0] = 8'd3;
      #1 chk("t1_grant", req_ar_ready, 4'b0001);
      cyc();
      req_ar_valid = '0;
      #1;
      chk("t1_ar_valid", mem_ar_valid, 1'b1);
      chk("t1_ar_addr", mem_ar_addr, 32'h1000);
      chk("t1_ar_id", mem_ar_id, 8'd0);
      chk("t1_ar_len", mem_ar_len, 8'd3);
      cyc();
      for (int b = 0; b < 4; b++) begin
         drive_mem(100);
         #1;
         chk("t1_r_valid", req_r_valid, 4'b0001);
         chk("t1_r_last", req_r_last, b == 3 ? 4'b0001 : 4'b0000);
         cyc();
      end
      mem_r_valid = 1'b0;
      #1 chk("t1_busy_end", busy, 1'b0);
      cyc();
      // all clients requesting: back-to-back RR grants 0,1,2,3,0,...
      async_rst();
      for (int k = 0; k < N; k++) begin
         req_ar_addr[k*32 +: 32] = $urandom;
         req_ar_len[k*8 +: 8] = 8'($urandom_range(3));
      end
      req_ar_valid = '1;
      for (int k = 0; k < 2 * N; k++) begin
         #1 chk("t2_grant", req_ar_ready, N'(1) << (k % N));
         if (k > 0) chk("t2_no_bubble", mem_ar_valid, 1'b1);
         cyc();
      end
      drain();
      // MAX_OUT limit on client 1
      async_rst();
      req_ar_len = '0;
      req_ar_valid = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         #1 chk("t3_ready", req_ar_ready, k < 2 ? 4'b0010 : 4'b0000);
         cyc();
      end
      drive_mem(100);
      #1;
      chk("t3_free_beat", req_r_last, 4'b0010);
      chk("t3_still_full", req_ar_ready, 4'b0000);
      cyc();
      mem_r_valid = 1'b0;
      #1 chk("t3_regrant", req_ar_ready, 4'b0010);
      cyc();
      drain();
      // AR backpressure: stage holds, no further grants
      async_rst();
      req_ar_valid = '1;
      mem_ar_ready = 1'b0;
      a0 = 32'hCAFE_0000;
      req_ar_addr[31:0] = a0;
      #1 chk("t4_first", req_ar_ready, 4'b0001);
      cyc();
      for (int k = 0; k < 5; k++) begin
         req_ar_addr = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk("t4_no_ready", req_ar_ready, 4'b0000);
         chk("t4_stable_addr", mem_ar_addr, a0);
         chk("t4_stable_id", mem_ar_id, 8'd0);
         cyc();
      end
      drain();
      // protocol errors
      async_rst();
      mem_r_valid = 1'b1;
      mem_r_id = 8'd7;
      mem_r_last = 1'b1;
      #1 chk("t5_bad_drop", req_r_valid, 4'b0000);
      cyc();
      mem_r_valid = 1'b0;
      #1 chk("t5_err_set", err, 1'b1);
      cyc();
      #1 chk("t5_err_sticky", err, 1'b1);
      cyc();
      async_rst();
      mem_r_valid = 1'b1;
      mem_r_id = 8'd2;
      mem_r_last = 1'b1;
      #1 chk("t5_orphan_routed", req_r_last, 4'b0100);
      cyc();
      mem_r_valid = 1'b0;
      #1;
      chk("t5_orphan_err", err, 1'b1);
      chk("t5_orphan_busy", busy, 1'b0);
      cyc();
      // reset mid-burst, then late beat and RR restart at 0
      async_rst();
      req_ar_valid = 4'b0001;
      req_ar_len[7:0] = 8'd3;
      cyc();
      req_ar_valid = '0;
      cyc();
      for (int b = 0; b < 2; b++) begin
         drive_mem(100);
         cyc();
      end
      async_rst();
      mem_r_valid = 1'b1;
      mem_r_id = 8'd0;
      mem_r_last = 1'b1;
      cyc();
      mem_r_valid = 1'b0;
      req_ar_valid = '1;
      #1;
      chk("t6_late_err", err, 1'b1);
      chk("t6_restart0", req_ar_ready, 4'b0001);
      cyc();
      drain();
      // randomized traffic
      async_rst();
      for (int i = 0; i < 3000; i++) begin
         req_ar_valid = N'($urandom);
         for (int k = 0; k < N; k++) begin
            req_ar_addr[k*32 +: 32] = $urandom;
            req_ar_len[k*8 +: 8] = 8'($urandom_range(3));
         end
         mem_ar_ready = $urandom_range(3) != 0;
         drive_mem(60);
         cyc();
         if (i == 1500) async_rst();
      end
      drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/vta_mem_read_arbiter.md
Name: vta_mem_read_arbiter

Overview:
Shares the single VTA memory AXI read channel (AR + R, 64-bit data, 8-bit id, no R backpressure) between NUM_REQ read clients, e.g. fetch, load, compute-uop and compute-acc. Each client's burst gets a round-robin grant and the grantee index as ar id. Returning beats are routed by r id. Sits between the VTA core read clients and the memory shell's mem_ar/mem_r ports.

Parameters:
NUM_REQ, 4, number of read clients (2..8)
ADDR_W, 32, AR address width
DATA_W, 64, R data width
LEN_W, 8, AXI burst length field (beats-1)
ID_W, 8, AR/R id width; must satisfy NUM_REQ <= 2^ID_W
MAX_OUT, 2, max outstanding bursts per client (1..7)

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-low reset
req_ar_valid  in  NUM_REQ  client i burst request
req_ar_ready  out  NUM_REQ  client i request accepted this cycle
req_ar_addr  in  NUM_REQ*ADDR_W  client i address, slice i
req_ar_len  in  NUM_REQ*LEN_W  client i burst length-1, slice i
req_r_valid  out  NUM_REQ  beat for client i
req_r_data  out  DATA_W  beat data, broadcast
req_r_last  out  NUM_REQ  last beat for client i
mem_ar_valid  out  1  AR to memory
mem_ar_ready  in  1  memory accepts AR
mem_ar_addr  out  ADDR_W  AR address
mem_ar_id  out  ID_W  grantee index, zero-extended
mem_ar_len  out  LEN_W  AR length
mem_r_valid  in  1  R beat (no ready; always accepted)
mem_r_data  in  DATA_W  R data
mem_r_last  in  1  R last
mem_r_id  in  ID_W  R id
busy  out  1  AR stage full or any outstanding count nonzero
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset=0, async): AR stage empty, mem_ar_valid=0, mem_ar_addr/id/len=0, all outstanding counters 0, RR pointer 0, err=0, busy=0. All req_ar_ready=0. req_r_* follow mem_r_* combinationally, so they are 0 while the memory is idle.
- AR stage: one output register (valid, addr, id, len). It may load when empty or when mem_ar_valid&&mem_ar_ready that cycle, so back-to-back issue is possible.
- Eligible client i: req_ar_valid[i] && out_cnt[i] < MAX_OUT.
- Grant: round-robin over eligible clients, starting at the index after the last grantee. When a load happens, req_ar_ready[grantee]=1 (combinational, same cycle) and the register captures that client's addr/len with id=i. mem_ar_valid appears the next cycle, giving latency 1 from request to mem_ar_valid.
- mem_ar_* stay stable while mem_ar_valid && !mem_ar_ready.
- out_cnt[i] increments on grant. It decrements on mem_r_valid && mem_r_last && mem_r_id==i. Increment and decrement in the same cycle leave it unchanged.
- R routing is combinational with zero latency: req_r_valid[i]=mem_r_valid && mem_r_id==i; req_r_last[i]=req_r_valid[i] && mem_r_last. Clients must sink every beat.
- Errors that set err (cleared only by reset):
  - mem_r_id >= NUM_REQ: the beat is dropped.
  - A last beat arrives for a client with out_cnt==0: the counter stays at 0 and the beat is still routed.
- Reset mid-burst clears everything. Late beats then raise err per the rule above.
- Client at MAX_OUT is skipped and the RR pointer moves on. The client is served once a last beat frees a slot.

Optional Feature:
VTA_MEM_ARB_PERF_EN:
- When defined, adds per-client 32-bit counters: grant count, and stall cycles where req_ar_valid=1 && req_ar_ready=0. Counters wrap and are exported on perf_grant (NUM_REQ*32) and perf_stall (NUM_REQ*32). Reset to 0.
- When undefined, these ports and registers are absent.

Decomposition:
- Package vta_mem_arb_pkg holds ADDR_W/DATA_W/LEN_W/ID_W defaults, the counter width function clog2(MAX_OUT+1), and the index type.
- One sub-module, vta_rr_arbiter: parameterised NUM_REQ round-robin picker (req vector, advance strobe → one-hot grant + index, internal pointer).

Test Plan:
- Single client 0 requests addr 0x1000 len 3, mem_ar_ready=1 → mem_ar_valid next cycle with id 0, len 3. Four R beats with id 0 → req_r_valid[0] four cycles, req_r_last[0] on the 4th, busy falls after the last beat.
- Clients 0..3 request continuously, mem_ar_ready=1 → ids issued 0,1,2,3,0,... with no bubble cycles.
- MAX_OUT=2, client 1 requests 3 bursts with no R → third request stalls (ready=0). One last beat id 1 → third grant the next cycle.
- mem_ar_ready held 0 for 5 cycles → mem_ar_* stable throughout, and no further req_ar_ready is asserted.
- R beat with id 7 (NUM_REQ=4) → no req_r_valid, err=1 and stays 1. Last beat id 2 with out_cnt[2]=0 → err, counter stays 0.
- reset=0 asynchronously mid-burst → outputs reach reset values immediately. After release, client arbitration restarts at index 0.
